host_link_bridge: RTL and testbench
===================================

Name: host_link_bridge

Overview:
- Host-side counterpart of the main_core_serialCmd command/data interface.
- Accepts a byte-wide framed stream from an external link and turns it into core commands (cmd/cmd_hasAny/cmd_consume) and 64-bit input words (in/in_isReady/in_canReceive).
- Drains core output words (out/out_isReady/out_canReceive) and serialises them back as bytes.
- Also drives config_matrixNumBlocks and a core reset, so a bare byte link can run full FrodoKEM test sequences.

Parameters:
- CMD_W, 16: width of the core cmd word (`MainCoreCMD_which_SIZE+`MainCoreSerialCMD_SIZE). CMD_BYTES = ceil(CMD_W/8) is derived.

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- rx_byte  in  8  link byte in
- rx_isReady  in  1  rx_byte valid
- rx_canReceive  out  1  bridge accepts rx_byte this cycle
- tx_byte  out  8  link byte out
- tx_isReady  out  1  tx_byte valid
- tx_canReceive  in  1  link accepts tx_byte
- cmd  out  CMD_W  core command
- cmd_hasAny  out  1  cmd valid
- cmd_consume  in  1  core takes cmd
- in  out  64  data word to core
- in_isReady  out  1  in valid
- in_canReceive  in  1  core accepts word
- out  in  64  core output word
- out_isReady  in  1  out valid
- out_canReceive  out  1  bridge takes core word
- config_matrixNumBlocks  out  9  matrix config to core
- core_rst  out  1  synchronous reset to core

Behaviour:
- Handshakes: a transfer occurs at a posedge where valid and ready are both high. Valid signals, once raised, hold with stable data until the transfer completes.
- Reset values: all valid/ready outputs 0, cmd 0, in 0, tx_byte 0, config_matrixNumBlocks 0, core_rst 0, state IDLE.
- Frames are an opcode byte followed by payload. Multi-byte fields are MSB-first; the first byte lands in bits [63:56] of a data word.
- Reset mid-frame discards partial state in the same cycle; no bytes are emitted.
- State machine:
  - IDLE: rx_canReceive=1. Opcode dispatch:
    - 0x00 -> RST
    - 0x01 -> CMDB
    - 0x02 -> DLEN
    - 0x03 -> RLEN
    - 0x04 -> CFG
    - any other value -> ERR
  - RST: core_rst=1 for exactly 2 cycles, then ACK.
  - CMDB: collect CMD_BYTES bytes into a shift register. The last byte goes to CMDW, and cmd is taken from the low CMD_W bits of the shift register.
  - CMDW: cmd_hasAny=1 until cmd_consume is sampled high. cmd and cmd_hasAny return to 0 in the next cycle, then go to ACK.
  - DLEN: one byte n gives a count of n+1 words (1..256). Then DBYTES.
  - DBYTES: collect 8 bytes into one word, then DPUSH.
  - DPUSH: rx_canReceive=0 and in_isReady=1 until in_canReceive. Then decrement the count and go to DBYTES, or to ACK when the count reaches 0.
  - RLEN: byte n gives n+1 words. Then RWAIT.
  - RWAIT: out_canReceive=1 for exactly one cycle-level handshake, which latches out. Then RTX.
  - RTX: emit the 8 bytes MSB-first, one per tx transfer. Then RWAIT again, or IDLE when the count is 0. Read frames send no ACK.
  - CFG: 2 bytes; config_matrixNumBlocks = {b0[0], b1}. Updates on the cycle of the second byte. Then ACK.
  - ACK: tx_byte=0xAC, tx_isReady=1 until the transfer completes, then IDLE.
  - ERR: tx_byte=0xEE until the transfer completes, then IDLE. No core signals are touched.
- rx_canReceive is 1 only in IDLE, CMDB, DLEN, DBYTES, RLEN and CFG. It is never high together with in_isReady, cmd_hasAny or out_canReceive.
- Byte stalls (rx_isReady=0) pause collection indefinitely without losing the partial word.
- A core stall (in_canReceive=0, cmd_consume=0, out_isReady=0) back-pressures the link by keeping rx_canReceive=0.
- Counters are 9 bits wide; there is no wrap beyond 256 words.

Test Plan:
- Reset then rx 01 12 34 -> cmd=0x1234 with cmd_hasAny held through a 3-cycle cmd_consume delay; then tx 0xAC.
- Rx 02 01 followed by 16 bytes 00..0F with in_canReceive toggling every cycle -> in=0x0001020304050607 then 0x08090A0B0C0D0E0F, each held until accepted; then tx 0xAC. rx_canReceive must be 0 during each push.
- Rx 03 00 with core out=0xDEADBEEFCAFEF00D and tx_canReceive low for 5 cycles -> out_canReceive is a single handshake; tx DE AD BE EF CA FE F0 0D in order; no ACK.
- Rx 04 01 FF -> config_matrixNumBlocks=0x1FF; tx 0xAC. Rx 00 -> core_rst high exactly 2 cycles; tx 0xAC.
- Rx 7F -> tx 0xEE; cmd_hasAny, in_isReady and out_canReceive stay 0.
- Assert rst after 3 of the 8 data bytes -> all outputs return to reset values next cycle. A following 01 00 05 frame yields cmd=0x0005 cleanly.

Source files
------------

// File: rtl/host_link_bridge_if.sv
// Link-side byte stream plus core-side cmd/data/config signals of host_link_bridge.
// master is the bridge's view; slave is the view of whatever sits on the other side.
interface host_link_bridge_if #(
    parameter int unsigned CMD_W = 16
) ();
    logic [7:0]       rx_byte;
    logic             rx_isReady;
    logic             rx_canReceive;
    logic [7:0]       tx_byte;
    logic             tx_isReady;
    logic             tx_canReceive;
    logic [CMD_W-1:0] cmd;
    logic             cmd_hasAny;
    logic             cmd_consume;
    logic [63:0]      in;
    logic             in_isReady;
    logic             in_canReceive;
    logic [63:0]      out;
    logic             out_isReady;
    logic             out_canReceive;
    logic [8:0]       config_matrixNumBlocks;
    logic             core_rst;

    modport master (
        input  rx_byte, rx_isReady, tx_canReceive, cmd_consume, in_canReceive, out, out_isReady,
        output rx_canReceive, tx_byte, tx_isReady, cmd, cmd_hasAny, in, in_isReady,
        output out_canReceive, config_matrixNumBlocks, core_rst
    );

    modport slave (
        output rx_byte, rx_isReady, tx_canReceive, cmd_consume, in_canReceive, out, out_isReady,
        input  rx_canReceive, tx_byte, tx_isReady, cmd, cmd_hasAny, in, in_isReady,
        input  out_canReceive, config_matrixNumBlocks, core_rst
    );
endinterface

// File: rtl/host_link_bridge.sv
// Host-side bridge: decodes framed link bytes into core commands, input words,
// config and core reset, and serialises core output words back onto the link.
module host_link_bridge #(
    parameter int unsigned CMD_W = 16
) (
    input logic                clk,
    input logic                rst,
    host_link_bridge_if.master bus
);
    localparam int unsigned CMD_BYTES = (CMD_W + 7) / 8;
    localparam logic [3:0]  CMD_LAST  = 4'(CMD_BYTES - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RST    = 4'd1;
    localparam logic [3:0] S_CMDB   = 4'd2;
    localparam logic [3:0] S_CMDW   = 4'd3;
    localparam logic [3:0] S_DLEN   = 4'd4;
    localparam logic [3:0] S_DBYTES = 4'd5;
    localparam logic [3:0] S_DPUSH  = 4'd6;
    localparam logic [3:0] S_RLEN   = 4'd7;
    localparam logic [3:0] S_RWAIT  = 4'd8;
    localparam logic [3:0] S_RTX    = 4'd9;
    localparam logic [3:0] S_CFG    = 4'd10;
    localparam logic [3:0] S_ACK    = 4'd11;
    localparam logic [3:0] S_ERR    = 4'd12;

    logic [3:0]       state_q, state_d;
    logic [63:0]      shift_q, shift_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [63:0]      in_q, in_d;
    logic [8:0]       cfg_q, cfg_d;

    logic       rx_ready;
    logic       rx_fire;
    logic       tx_valid;
    logic [7:0] tx_data;

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_IDLE, S_CMDB, S_DLEN, S_DBYTES, S_RLEN, S_CFG: rx_ready = 1'b1;
            default:                                        rx_ready = 1'b0;
        endcase
    end

    // Gating with rst keeps a reset cycle from completing any handshake on either side.
    assign rx_fire                    = bus.rx_isReady && rx_ready && !rst;
    assign bus.rx_canReceive          = rx_ready && !rst;
    assign bus.tx_isReady             = tx_valid && !rst;
    assign bus.tx_byte                = tx_data;
    assign bus.cmd                    = cmd_q;
    assign bus.cmd_hasAny             = (state_q == S_CMDW) && !rst;
    assign bus.in                     = in_q;
    assign bus.in_isReady             = (state_q == S_DPUSH) && !rst;
    assign bus.out_canReceive         = (state_q == S_RWAIT) && !rst;
    assign bus.config_matrixNumBlocks = cfg_q;
    assign bus.core_rst               = (state_q == S_RST) && !rst;

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        case (state_q)
            S_RTX: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[63:56];
            end
            S_ACK: begin
                tx_valid = 1'b1;
                tx_data  = 8'hAC;
            end
            S_ERR: begin
                tx_valid = 1'b1;
                tx_data  = 8'hEE;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        cmd_d   = cmd_q;
        in_d    = in_q;
        cfg_d   = cfg_q;
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    bcnt_d = '0;
                    case (bus.rx_byte)
                        8'h00:   state_d = S_RST;
                        8'h01:   state_d = S_CMDB;
                        8'h02:   state_d = S_DLEN;
                        8'h03:   state_d = S_RLEN;
                        8'h04:   state_d = S_CFG;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_RST: begin
                if (bcnt_q == 4'd1) begin
                    state_d = S_ACK;
                end else begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            S_CMDB: begin
                if (rx_fire) begin
                    shift_d = {shift_q[55:0], bus.rx_byte};
                    if (bcnt_q == CMD_LAST) begin
                        cmd_d   = shift_d[CMD_W-1:0];
                        state_d = S_CMDW;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            S_CMDW: begin
                if (bus.cmd_consume) begin
                    cmd_d   = '0;
                    state_d = S_ACK;
                end
            end
            S_DLEN: begin
                if (rx_fire) begin
                    cnt_d   = {1'b0, bus.rx_byte} + 9'd1;
                    bcnt_d  = '0;
                    state_d = S_DBYTES;
                end
            end
            S_DBYTES: begin
                if (rx_fire) begin
                    shift_d = {shift_q[55:0], bus.rx_byte};
                    if (bcnt_q == 4'd7) begin
                        in_d    = shift_d;
                        state_d = S_DPUSH;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            S_DPUSH: begin
                if (bus.in_canReceive) begin
                    cnt_d   = cnt_q - 9'd1;
                    bcnt_d  = '0;
                    state_d = (cnt_q == 9'd1) ? S_ACK : S_DBYTES;
                end
            end
            S_RLEN: begin
                if (rx_fire) begin
                    cnt_d   = {1'b0, bus.rx_byte} + 9'd1;
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                // Count is consumed when a word is latched, so RTX only tests for zero.
                if (bus.out_isReady) begin
                    shift_d = bus.out;
                    cnt_d   = cnt_q - 9'd1;
                    bcnt_d  = '0;
                    state_d = S_RTX;
                end
            end
            S_RTX: begin
                if (bus.tx_canReceive) begin
                    shift_d = {shift_q[55:0], 8'h00};
                    if (bcnt_q == 4'd7) begin
                        state_d = (cnt_q == 9'd0) ? S_IDLE : S_RWAIT;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            S_CFG: begin
                if (rx_fire) begin
                    if (bcnt_q == 4'd0) begin
                        shift_d[0] = bus.rx_byte[0];
                        bcnt_d     = 4'd1;
                    end else begin
                        cfg_d   = {shift_q[0], bus.rx_byte};
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK, S_ERR: begin
                if (bus.tx_canReceive) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            cmd_q   <= '0;
            in_q    <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            cmd_q   <= cmd_d;
            in_q    <= in_d;
            cfg_q   <= cfg_d;
        end
    end
endmodule

// File: tb/tb_host_link_bridge.sv
// Self-checking bench for host_link_bridge: frames are built from random bytes and the
// expected commands, words and link bytes are computed directly from the frame contents.
module tb_host_link_bridge;
    localparam int unsigned CMD_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    host_link_bridge_if #(.CMD_W(CMD_W)) bus ();
    host_link_bridge #(.CMD_W(CMD_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Observed handshakes and activity counters (collected mid-cycle).
    logic [7:0]       obs_tx[$];
    logic [CMD_W-1:0] obs_cmd[$];
    logic [63:0]      obs_in[$];
    int out_hs, out_rdy_cyc, cmd_cyc, in_cyc, core_rst_cyc, overlap_err, stable_err;

    // Core/link responder controls.
    int          cmd_delay = 0;
    int          cmd_wait  = 0;
    bit          in_toggle = 0;
    bit          tx_random = 0;
    int          tx_hold   = 0;
    bit          rx_gaps   = 0;
    bit          out_taken = 0;
    logic [63:0] out_q[$];
    logic [8:0]  exp_cfg = '0;

    logic             p_tx_pend, p_in_pend, p_cmd_pend;
    logic [7:0]       p_tx;
    logic [63:0]      p_in;
    logic [CMD_W-1:0] p_cmd;

    always @(posedge clk) begin
        #1;
        if (out_taken) begin
            out_q.delete(0);
            out_taken = 0;
        end
        bus.out_isReady = (out_q.size() > 0);
        bus.out         = (out_q.size() > 0) ? out_q[0] : 64'h0;
        if (bus.cmd_hasAny) begin
            bus.cmd_consume = (cmd_wait >= cmd_delay);
            cmd_wait++;
        end else begin
            bus.cmd_consume = 1'b0;
            cmd_wait        = 0;
        end
        bus.in_canReceive = in_toggle ? ~bus.in_canReceive : 1'b1;
        if (tx_hold > 0) begin
            bus.tx_canReceive = 1'b0;
            tx_hold--;
        end else begin
            bus.tx_canReceive = tx_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_isReady && bus.tx_canReceive) obs_tx.push_back(bus.tx_byte);
            if (bus.cmd_hasAny && bus.cmd_consume) obs_cmd.push_back(bus.cmd);
            if (bus.in_isReady && bus.in_canReceive) obs_in.push_back(bus.in);
            if (bus.out_isReady && bus.out_canReceive) begin
                out_hs++;
                out_taken = 1;
            end
            if (bus.out_canReceive) out_rdy_cyc++;
            if (bus.cmd_hasAny) cmd_cyc++;
            if (bus.in_isReady) in_cyc++;
            if (bus.core_rst) core_rst_cyc++;
            if (bus.rx_canReceive && (bus.in_isReady || bus.cmd_hasAny || bus.out_canReceive)) overlap_err++;
            if (p_tx_pend && (!bus.tx_isReady || bus.tx_byte !== p_tx)) stable_err++;
            if (p_in_pend && (!bus.in_isReady || bus.in !== p_in)) stable_err++;
            if (p_cmd_pend && (!bus.cmd_hasAny || bus.cmd !== p_cmd)) stable_err++;
        end
        p_tx_pend  = !rst && bus.tx_isReady && !bus.tx_canReceive;
        p_in_pend  = !rst && bus.in_isReady && !bus.in_canReceive;
        p_cmd_pend = !rst && bus.cmd_hasAny && !bus.cmd_consume;
        p_tx  = bus.tx_byte;
        p_in  = bus.in;
        p_cmd = bus.cmd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_tx.delete();
        obs_cmd.delete();
        obs_in.delete();
        out_hs = 0; out_rdy_cyc = 0; cmd_cyc = 0; in_cyc = 0;
        core_rst_cyc = 0; overlap_err = 0; stable_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        if (rx_gaps) repeat ($urandom_range(0, 2)) tick();
        bus.rx_byte    = b;
        bus.rx_isReady = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (bus.rx_canReceive) done = 1;
            tick();
        end
        bus.rx_isReady = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL rx_timeout: byte %h never accepted (required acceptance within 500 cycles)", b);
        end
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 5000 && obs_tx.size() < n; i++) tick();
        if (obs_tx.size() < n) begin
            tests++; fails++;
            $display("FAIL tx_timeout: got %0d link bytes, required %0d", obs_tx.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        tests++;
        if ({bus.rx_canReceive, bus.tx_isReady, bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive, bus.core_rst} !== 6'b0) begin
            fails++;
            $display("FAIL reset_handshakes: got %b, required 000000",
                     {bus.rx_canReceive, bus.tx_isReady, bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive, bus.core_rst});
        end
        tests++;
        if ({bus.cmd, bus.in, bus.tx_byte, bus.config_matrixNumBlocks} !== '0) begin
            fails++;
            $display("FAIL reset_data: cmd=%h in=%h tx=%h cfg=%h, required all zero",
                     bus.cmd, bus.in, bus.tx_byte, bus.config_matrixNumBlocks);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.rx_canReceive !== 1'b1) begin
            fails++;
            $display("FAIL idle_rx_ready: got %b, required 1", bus.rx_canReceive);
        end
        tick();
    endtask

    task automatic test_cmd();
        logic [15:0] v;
        clear_obs();
        cmd_delay = 3;
        rx_gaps   = 0;
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        wait_tx(1);
        repeat (2) tick();
        tests++;
        if (obs_cmd.size() != 1 || obs_cmd[0] !== 16'h1234) begin
            fails++;
            $display("FAIL cmd_value: got %0d cmds first=%h, required 1 cmd 1234", obs_cmd.size(), obs_cmd[0]);
        end
        tests++;
        if (cmd_cyc != 4 || stable_err != 0) begin
            fails++;
            $display("FAIL cmd_hold: hasAny cycles=%0d unstable=%0d, required 4 and 0", cmd_cyc, stable_err);
        end
        tests++;
        if (obs_tx.size() != 1 || obs_tx[0] !== 8'hAC) begin
            fails++;
            $display("FAIL cmd_ack: got %0d bytes first=%h, required 1 byte AC", obs_tx.size(), obs_tx[0]);
        end
        tests++;
        if (bus.cmd !== '0 || bus.cmd_hasAny !== 1'b0) begin
            fails++;
            $display("FAIL cmd_clear: cmd=%h hasAny=%b, required 0000 and 0", bus.cmd, bus.cmd_hasAny);
        end
        for (int k = 0; k < 4; k++) begin
            clear_obs();
            v         = 16'($urandom);
            cmd_delay = $urandom_range(0, 4);
            rx_gaps   = 1;
            send_byte(8'h01); send_byte(v[15:8]); send_byte(v[7:0]);
            wait_tx(1);
            tick();
            tests++;
            if (obs_cmd.size() != 1 || obs_cmd[0] !== v || cmd_cyc != cmd_delay + 1 || obs_tx[0] !== 8'hAC) begin
                fails++;
                $display("FAIL cmd_random: got cmd=%h cycles=%0d ack=%h, required cmd=%h cycles=%0d ack=AC",
                         obs_cmd[0], cmd_cyc, obs_tx[0], v, cmd_delay + 1);
            end
        end
        rx_gaps = 0;
    endtask

    task automatic run_data(input logic [7:0] n, input bit rand_bytes, input string name);
        logic [63:0] exp[$];
        logic [63:0] w;
        logic [7:0]  b;
        int          bad;
        clear_obs();
        send_byte(8'h02);
        send_byte(n);
        for (int i = 0; i <= int'(n); i++) begin
            w = '0;
            for (int j = 0; j < 8; j++) begin
                b = rand_bytes ? 8'($urandom) : 8'(i * 8 + j);
                w = {w[55:0], b};
                send_byte(b);
            end
            exp.push_back(w);
        end
        wait_tx(1);
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < exp.size() && i < obs_in.size(); i++) if (obs_in[i] !== exp[i]) bad++;
        tests++;
        if (obs_in.size() != exp.size() || bad != 0) begin
            fails++;
            $display("FAIL %s words: got %0d words (%0d wrong) first=%h, required %0d first=%h",
                     name, obs_in.size(), bad, obs_in[0], exp.size(), exp[0]);
        end
        tests++;
        if (obs_tx.size() != 1 || obs_tx[0] !== 8'hAC || overlap_err != 0 || stable_err != 0) begin
            fails++;
            $display("FAIL %s ack: bytes=%0d first=%h overlap=%0d unstable=%0d, required 1 AC 0 0",
                     name, obs_tx.size(), obs_tx[0], overlap_err, stable_err);
        end
    endtask

    task automatic test_data();
        rx_gaps   = 0;
        in_toggle = 1;
        run_data(8'h01, 0, "data_fixed");
        rx_gaps = 1;
        for (int k = 0; k < 3; k++) run_data(8'($urandom_range(0, 3)), 1, "data_random");
        rx_gaps   = 0;
        in_toggle = 0;
        run_data(8'hFF, 1, "data_256");
    endtask

    task automatic run_read(input int k, input string name);
        logic [7:0] exp[$];
        logic [63:0] w;
        int bad;
        clear_obs();
        for (int i = 0; i < k; i++) begin
            w = (i == 0 && k == 1) ? 64'hDEADBEEFCAFEF00D : {32'($urandom), 32'($urandom)};
            out_q.push_back(w);
            for (int j = 7; j >= 0; j--) exp.push_back(8'(w >> (8 * j)));
        end
        send_byte(8'h03);
        send_byte(8'(k - 1));
        tx_hold = 5;
        wait_tx(8 * k);
        repeat (20) tick();
        bad = 0;
        for (int i = 0; i < exp.size() && i < obs_tx.size(); i++) if (obs_tx[i] !== exp[i]) bad++;
        tests++;
        if (obs_tx.size() != exp.size() || bad != 0) begin
            fails++;
            $display("FAIL %s bytes: got %0d bytes (%0d wrong) first=%h, required %0d first=%h",
                     name, obs_tx.size(), bad, obs_tx[0], exp.size(), exp[0]);
        end
        tests++;
        if (out_hs != k || out_rdy_cyc != k || overlap_err != 0 || stable_err != 0) begin
            fails++;
            $display("FAIL %s out_hs: handshakes=%0d ready_cycles=%0d overlap=%0d unstable=%0d, required %0d %0d 0 0",
                     name, out_hs, out_rdy_cyc, overlap_err, stable_err, k, k);
        end
    endtask

    task automatic test_read();
        tx_random = 0;
        run_read(1, "read_fixed");
        tx_random = 1;
        rx_gaps   = 1;
        for (int r = 0; r < 2; r++) run_read($urandom_range(1, 3), "read_random");
        tx_random = 0;
        rx_gaps   = 0;
    endtask

    task automatic test_cfg();
        logic [7:0] b0, b1;
        clear_obs();
        send_byte(8'h04); send_byte(8'h01); send_byte(8'hFF);
        wait_tx(1);
        tick();
        exp_cfg = 9'h1FF;
        tests++;
        if (bus.config_matrixNumBlocks !== 9'h1FF || obs_tx[0] !== 8'hAC) begin
            fails++;
            $display("FAIL cfg_fixed: cfg=%h ack=%h, required 1ff and AC", bus.config_matrixNumBlocks, obs_tx[0]);
        end
        for (int k = 0; k < 3; k++) begin
            clear_obs();
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            send_byte(8'h04); send_byte(b0); send_byte(b1);
            wait_tx(1);
            tick();
            exp_cfg = {b0[0], b1};
            tests++;
            if (bus.config_matrixNumBlocks !== exp_cfg || obs_tx[0] !== 8'hAC) begin
                fails++;
                $display("FAIL cfg_random: cfg=%h ack=%h, required %h and AC", bus.config_matrixNumBlocks, obs_tx[0], exp_cfg);
            end
        end
    endtask

    task automatic test_core_rst();
        clear_obs();
        send_byte(8'h00);
        wait_tx(1);
        repeat (3) tick();
        tests++;
        if (core_rst_cyc != 2 || obs_tx.size() != 1 || obs_tx[0] !== 8'hAC) begin
            fails++;
            $display("FAIL core_rst: high cycles=%0d bytes=%0d first=%h, required 2 cycles 1 byte AC",
                     core_rst_cyc, obs_tx.size(), obs_tx[0]);
        end
    endtask

    task automatic test_err();
        logic [7:0] op;
        for (int k = 0; k < 5; k++) begin
            clear_obs();
            op = (k == 0) ? 8'h7F : 8'($urandom_range(5, 255));
            send_byte(op);
            wait_tx(1);
            repeat (5) tick();
            tests++;
            if (obs_tx.size() != 1 || obs_tx[0] !== 8'hEE) begin
                fails++;
                $display("FAIL err_byte op=%h: bytes=%0d first=%h, required 1 byte EE", op, obs_tx.size(), obs_tx[0]);
            end
            tests++;
            if (cmd_cyc + in_cyc + out_rdy_cyc + core_rst_cyc != 0 || bus.config_matrixNumBlocks !== exp_cfg) begin
                fails++;
                $display("FAIL err_quiet op=%h: core activity=%0d cfg=%h, required 0 and %h",
                         op, cmd_cyc + in_cyc + out_rdy_cyc + core_rst_cyc, bus.config_matrixNumBlocks, exp_cfg);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rst = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if ({bus.rx_canReceive, bus.tx_isReady, bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive, bus.core_rst} !== 6'b0 ||
            {bus.cmd, bus.in, bus.tx_byte, bus.config_matrixNumBlocks} !== '0) begin
            fails++;
            $display("FAIL midframe_reset: hs=%b cmd=%h in=%h tx=%h cfg=%h, required all zero",
                     {bus.rx_canReceive, bus.tx_isReady, bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive, bus.core_rst},
                     bus.cmd, bus.in, bus.tx_byte, bus.config_matrixNumBlocks);
        end
        tick();
        rst     = 1'b0;
        exp_cfg = '0;
        clear_obs();
        cmd_delay = 1;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        wait_tx(1);
        repeat (5) tick();
        tests++;
        if (obs_cmd.size() != 1 || obs_cmd[0] !== 16'h0005 || obs_in.size() != 0 ||
            obs_tx.size() != 1 || obs_tx[0] !== 8'hAC) begin
            fails++;
            $display("FAIL post_reset_cmd: cmds=%0d first=%h words=%0d bytes=%0d first=%h, required 1 0005 0 1 AC",
                     obs_cmd.size(), obs_cmd[0], obs_in.size(), obs_tx.size(), obs_tx[0]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_byte       = '0;
        bus.rx_isReady    = 1'b0;
        bus.tx_canReceive = 1'b0;
        bus.cmd_consume   = 1'b0;
        bus.in_canReceive = 1'b0;
        bus.out           = '0;
        bus.out_isReady   = 1'b0;
        clear_obs();
        test_reset();
        test_cmd();
        test_data();
        test_read();
        test_cfg();
        test_core_rst();
        test_err();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
